// File: rtl/wb_burst_reader_if.sv
// Wishbone B4 classic/registered-feedback bus bundle between the burst reader
// and a memory slave.
interface wb_burst_reader_if;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;

    modport master (output adr, cyc, stb, we, sel, cti, bte, input dat, ack);
    modport slave  (input adr, cyc, stb, we, sel, cti, bte, output dat, ack);
endinterface

// File: rtl/wb_burst_reader.sv
// Wishbone read master: fetches nwords 32-bit words in incrementing bursts into
// a fall-through FIFO and streams them out on valid/ready.
module wb_burst_reader #(
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 2 * BURST_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           base_adr,
    input  logic [15:0]           nwords,
    output logic                  busy,
    output logic                  done,
    wb_burst_reader_if.master     wb,
    output logic [31:0]           data_o,
    output logic                  valid_o,
    input  logic                  ready_i
);
    localparam int BW = $clog2(BURST_LEN) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [BW-1:0] BL = BW'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, REQ, BURST, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [31:0]     cur_adr_q, cur_adr_d;
    logic [15:0]     remaining_q, remaining_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [BW-1:0]   blen_q, blen_d;
    logic            gap_q, gap_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            cyc_q, cyc_d;
    logic [31:0]     adr_q, adr_d;
    logic [2:0]      cti_q, cti_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     mem_q [FIFO_DEPTH];

    logic            push, pop;
    logic [BW-1:0]   req_blen;
    logic [CW-1:0]   free;

    assign push     = (state_q == BURST) && wb.ack;
    assign pop      = valid_o && ready_i;
    assign req_blen = (remaining_q < 16'(BURST_LEN)) ? remaining_q[BW-1:0] : BL;
    assign free     = CW'(FIFO_DEPTH) - count_q;

    always_comb begin
        state_d     = state_q;
        cur_adr_d   = cur_adr_q;
        remaining_d = remaining_q;
        beat_d      = beat_q;
        blen_d      = blen_q;
        gap_d       = gap_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cyc_d       = cyc_q;
        adr_d       = adr_q;
        cti_d       = cti_q;
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q + CW'(push) - CW'(pop);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (nwords == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        cur_adr_d   = base_adr & ~32'h3;
                        remaining_d = nwords;
                        busy_d      = 1'b1;
                        gap_d       = 1'b0;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                // One extra idle cycle after a burst keeps cyc_o low for two cycles.
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (free >= CW'(req_blen)) begin
                    blen_d  = req_blen;
                    beat_d  = '0;
                    cyc_d   = 1'b1;
                    adr_d   = cur_adr_q;
                    cti_d   = (req_blen == BW'(1)) ? 3'b111 : 3'b010;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (wb.ack) begin
                    cur_adr_d   = cur_adr_q + 32'd4;
                    remaining_d = remaining_q - 16'd1;
                    beat_d      = beat_q + BW'(1);
                    if (beat_q == blen_q - BW'(1)) begin
                        cyc_d   = 1'b0;
                        cti_d   = 3'b000;
                        gap_d   = 1'b1;
                        state_d = (remaining_q != 16'd1) ? REQ : DRAIN;
                    end else begin
                        adr_d = cur_adr_q + 32'd4;
                        cti_d = (beat_q + BW'(1) == blen_q - BW'(1)) ? 3'b111 : 3'b010;
                    end
                end
            end
            DRAIN: begin
                if (count_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_adr_q   <= '0;
            remaining_q <= '0;
            beat_q      <= '0;
            blen_q      <= '0;
            gap_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cyc_q       <= 1'b0;
            adr_q       <= '0;
            cti_q       <= 3'b000;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cur_adr_q   <= cur_adr_d;
            remaining_q <= remaining_d;
            beat_q      <= beat_d;
            blen_q      <= blen_d;
            gap_q       <= gap_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cyc_q       <= cyc_d;
            adr_q       <= adr_d;
            cti_q       <= cti_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wb.dat;
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign wb.adr  = adr_q;
    assign wb.cyc  = cyc_q;
    assign wb.stb  = cyc_q;
    assign wb.we   = 1'b0;
    assign wb.sel  = 4'hF;
    assign wb.cti  = cti_q;
    assign wb.bte  = 2'b00;
    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
endmodule

// File: tb/tb_wb_burst_reader.sv
// Scoreboard bench for wb_burst_reader: stimulus queues expected words and
// transfers, a negedge monitor checks the Wishbone bus and the output stream.
module tb_wb_burst_reader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_adr;
    logic [15:0] nwords;
    logic        busy, done;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;

    int total = 0;
    int bad   = 0;
    int waits = 0;
    int wcnt  = 0;
    int done_cnt = 0;
    int ack_cnt  = 0;
    int d0 = 0;

    logic [31:0] sq[$];
    logic [47:0] tq[$];

    wb_burst_reader_if wbif ();

    wb_burst_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr),
        .nwords(nwords), .busy(busy), .done(done), .wb(wbif),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + a[15:0] + 16'h0101};
    endfunction

    // Slave: memory with a programmable number of wait states per beat.
    assign wbif.dat = memf(wbif.adr);
    assign wbif.ack = wbif.cyc && wbif.stb && (wcnt == waits);
    always @(posedge clk) begin
        if (wbif.cyc && wbif.stb && !wbif.ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: bus protocol, addresses, burst shapes and stream data.
    logic        prev_cyc = 1'b0;
    logic [31:0] exp_adr = '0;
    int          rem_exp = 0, blen_exp = 0, beat = 0, gap = 99;
    always @(negedge clk) begin
        logic [47:0] t;
        if (!rst_n) begin
            prev_cyc = 1'b0; rem_exp = 0; beat = 0; gap = 99;
        end else begin
            if (done) done_cnt++;
            if (valid_o && ready_i) begin
                if (sq.size() == 0) chk("stream_extra", data_o, 32'hxxxx_xxxx);
                else chk("stream_data", data_o, sq.pop_front());
            end
            if (wbif.cyc && !prev_cyc) begin
                if (rem_exp == 0) begin
                    if (tq.size() == 0) chk("unexpected_cyc", 32'd1, 32'd0);
                    else begin
                        t = tq.pop_front();
                        exp_adr = t[47:16];
                        rem_exp = int'(t[15:0]);
                        gap = 99;
                    end
                end
                chk("burst_gap", 32'(gap >= 2), 32'd1);
                blen_exp = (rem_exp < 16) ? rem_exp : 16;
                beat = 0;
            end
            if (wbif.cyc) begin
                gap = 0;
                chk("adr", wbif.adr, exp_adr);
                chk("cti", 32'(wbif.cti), (beat == blen_exp - 1) ? 32'd7 : 32'd2);
                chk("static", {wbif.stb, wbif.we, wbif.sel, wbif.bte}, 32'b1_0_1111_00);
                if (wbif.ack) begin
                    exp_adr = exp_adr + 32'd4;
                    beat++; rem_exp--; ack_cnt++;
                end
            end else begin
                gap++;
                if (prev_cyc) chk("burst_len", beat, blen_exp);
            end
            prev_cyc = wbif.cyc;
        end
    end

    task automatic go(input logic [31:0] b, input logic [15:0] n);
        d0 = done_cnt;
        for (int i = 0; i < int'(n); i++) sq.push_back(memf((b & ~32'h3) + 32'(4 * i)));
        if (n != 0) tq.push_back({b & ~32'h3, n});
        @(posedge clk); #1;
        start = 1'b1; base_adr = b; nwords = n;
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) begin
            chk("zero_done", done, 1'b1);
            chk("zero_busy", busy, 1'b0);
        end else begin
            chk("busy_set", busy, 1'b1);
            chk("cyc_not_yet", wbif.cyc, 1'b0);
            @(posedge clk); #1;
            chk("start_to_cyc", wbif.cyc, 1'b1);
        end
    endtask

    task automatic finish_xfer();
        int k = 0;
        while (done !== 1'b1 && k < 20000) begin
            @(posedge clk); #1; k++;
        end
        if (k >= 20000) chk("done_timeout", 32'd0, 32'd1);
        else chk("busy_with_done", busy, 1'b0);
        @(posedge clk); #1;
        chk("done_once", done_cnt - d0, 32'd1);
        chk("sq_empty", sq.size(), 32'd0);
        chk("done_pulse", done, 1'b0);
    endtask

    task automatic wait_acks(input int a0, input int n);
        int k = 0;
        while (ack_cnt - a0 < n && k < 2000) begin
            @(posedge clk); #1; k++;
        end
        if (k >= 2000) chk("ack_timeout", ack_cnt - a0, n);
    endtask

    initial begin
        int a0;
        rst_n = 1'b0; start = 1'b0; base_adr = '0; nwords = '0; ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cyc", wbif.cyc, 1'b0);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_adr", wbif.adr, 32'h0);
        chk("rst_cti", 32'(wbif.cti), 32'd0);
        rst_n = 1'b1;

        go(32'h103, 16'd1);          finish_xfer();
        go(32'h0, 16'd16);           finish_xfer();
        go(32'h0, 16'd40);           finish_xfer();
        go(32'h0, 16'd0);            finish_xfer();
        go(32'hFFFF_FFF8, 16'd4);    finish_xfer();

        // Stalled consumer: FIFO fills after two bursts, third waits for space.
        ready_i = 1'b0;
        a0 = ack_cnt;
        go(32'h1000, 16'd40);
        repeat (150) @(posedge clk);
        #1;
        chk("stall_acks", ack_cnt - a0, 32'd32);
        chk("stall_cyc", wbif.cyc, 1'b0);
        chk("stall_valid", valid_o, 1'b1);
        ready_i = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        ready_i = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("third_burst_acks", ack_cnt - a0, 32'd40);
        ready_i = 1'b1;
        finish_xfer();

        // Wait-state slave and a start pulse that must be ignored.
        waits = 3;
        go(32'h800, 16'd12);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; base_adr = 32'h5000; nwords = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        finish_xfer();
        waits = 0;

        // Reset in the middle of a burst, then a clean transfer.
        a0 = ack_cnt;
        go(32'h400, 16'd16);
        wait_acks(a0, 5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_cyc", wbif.cyc, 1'b0);
        chk("mid_rst_valid", valid_o, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        sq.delete(); tq.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        go(32'h2000, 16'd5);
        finish_xfer();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
